fp_sqrt_result_buffer: RTL and testbench
========================================

# fp_sqrt_result_buffer

Result buffer and credit tracker placed directly downstream of the FP square-root wrapper inside the shared APU. The wrapper has no back-pressure, with `Ready_o` tied high and results appearing a fixed number of cycles after `En_i`. This block captures every result into a FIFO and returns it to the cluster interconnect over a valid/ready handshake. It also issues credits to the APU dispatcher so that a square-root operation is only started when a buffer slot is guaranteed.

## Interface
- `FP_WIDTH`, 32, result width
- `TAG_WIDTH`, 5, tag width (≥1)
- `STAT_WIDTH`, 5, status flag width
- `DEPTH`, 4, FIFO entries (≥1; need not be a power of two)

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock, synchronous, active-high
- `Issue_i`  in  1  dispatcher starts a sqrt op this cycle (same cycle as wrapper `En_i`)
- `CanIssue_o`  out  1  credit available; dispatcher may assert `Issue_i`
- `SqrtValid_i`  in  1  wrapper result valid
- `SqrtRes_i`  in  FP_WIDTH  wrapper result
- `SqrtTag_i`  in  TAG_WIDTH  wrapper tag
- `SqrtStatus_i`  in  STAT_WIDTH  wrapper status
- `Valid_o`  out  1  head entry valid towards interconnect
- `Ready_i`  in  1  interconnect accepts head entry
- `Res_o`  out  FP_WIDTH  head result
- `Tag_o`  out  TAG_WIDTH  head tag
- `Status_o`  out  STAT_WIDTH  head status
- `Empty_o`  out  1  FIFO empty and no credits outstanding (unit idle)
- `Overflow_o`  out  1  sticky error: result arrived while FIFO full

## Operation
- **Credit counter** `Credits_SP`, width $clog2(DEPTH+1):
  - Reset value is DEPTH.
  - `CanIssue_o = (Credits_SP != 0)`.
  - Issue accepted = `Issue_i & CanIssue_o`; `Issue_i` while `CanIssue_o=0` is ignored and the count is unchanged.
  - Pop = `Valid_o & Ready_i`.
  - Issue accepted, no pop: decrement. Pop, no issue: increment. Both: unchanged.
  - The counter never exceeds DEPTH and never underflows. A pop at DEPTH is impossible by construction.
- **FIFO**: circular, DEPTH entries of {Res, Tag, Status}.
  - Write and read pointers wrap from DEPTH-1 to 0.
  - Occupancy counter has width $clog2(DEPTH+1).
  - Push = `SqrtValid_i` and FIFO not full. Data is written at the write pointer.
  - Head is presented from the read pointer (first-word fall-through from storage, no bypass). `Valid_o = (occupancy != 0)`.
  - Simultaneous push and pop: occupancy unchanged, both pointers advance. This is legal when full (pop frees the slot in the same cycle) and when empty is not applicable (push is not visible same cycle).
  - While `Valid_o=1 & Ready_i=0`, `Res_o`, `Tag_o` and `Status_o` hold stable.
- **Overflow**: `SqrtValid_i` while occupancy==DEPTH and no pop in that cycle:
  - the entry is dropped,
  - `Overflow_o` is set and stays set until reset,
  - pointers and occupancy are unchanged.
  - This can only happen if the dispatcher ignores credits.
- **Empty_o** = `(occupancy==0) & (Credits_SP==DEPTH)`.
- **Reset** (any cycle, including mid-operation):
  - pointers, occupancy and `Overflow_o` clear; `Credits_SP` is set to DEPTH.
  - In-flight wrapper results are not cancelled by this block. The dispatcher and wrapper are reset on the same `rst_i`.
  - Storage contents need no reset.

## Timing
- Result latency: `SqrtValid_i` in cycle N gives `Valid_o` in cycle N+1 if the FIFO was empty, with `Res_o`, `Tag_o` and `Status_o` equal to the cycle-N inputs.
- Credit return: a pop in cycle N gives the incremented `CanIssue_o` in cycle N+1. There is no combinational path from `Ready_i` to `CanIssue_o`.
- `CanIssue_o`, `Valid_o`, `Empty_o` and `Overflow_o` are decoded from registers only. No combinational input-to-output paths exist.
- Reset values:
  - `CanIssue_o=1`, `Valid_o=0`, `Empty_o=1`, `Overflow_o=0`.
  - `Res_o`, `Tag_o` and `Status_o` are don't-care while `Valid_o=0`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Single op:** reset; `Issue_i` in cycle 1; `SqrtValid_i` with Res=0x40000000, Tag=3 in cycle 3; `Ready_i=1`.
  - `CanIssue_o` stays 1 and the credit count is 3 after cycle 1.
  - `Valid_o` rises in cycle 4 with Res 0x40000000, Tag 3; pop occurs in cycle 4.
  - Credits return to 4 in cycle 5, and `Empty_o=1` from cycle 5.
- **Credit exhaustion:** issue 4 ops back-to-back with `Ready_i=0`.
  - `CanIssue_o=0` after the 4th issue.
  - A 5th `Issue_i` is ignored and the count stays 0.
  - One pop restores `CanIssue_o=1` the next cycle.
- **Full FIFO with simultaneous push/pop:** FIFO holds 4 entries, Tags 0–3. In one cycle assert `SqrtValid_i` (Tag 4) and `Ready_i`.
  - Tag 0 is popped and Tag 4 is accepted; `Overflow_o` stays 0.
  - Subsequent pops yield Tags 1, 2, 3, 4 in order, covering pointer wrap.
- **Overflow:** FIFO full, `SqrtValid_i` with Tag 7 and `Ready_i=0`.
  - `Overflow_o=1` the next cycle and stays high.
  - Draining yields only the original 4 tags.
- **Back-pressure hold:** `Valid_o=1` and `Ready_i=0` for 5 cycles while new results arrive.
  - `Res_o`, `Tag_o` and `Status_o` are unchanged across all 5 cycles.
- **Reset mid-operation:** 2 entries buffered and 1 credit outstanding; pulse `rst_i`.
  - Next cycle: `Valid_o=0`, `CanIssue_o=1`, `Empty_o=1`, and `Overflow_o` cleared.

Source files
------------

// File: rtl/fp_sqrt_result_buffer_if.sv
// Handshake bundle between the sqrt wrapper/dispatcher/interconnect and the result buffer.
// The slave modport is the buffer's view.
interface fp_sqrt_result_buffer_if #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned STAT_WIDTH = 5
);
  logic                  Issue_i;
  logic                  CanIssue_o;
  logic                  SqrtValid_i;
  logic [FP_WIDTH-1:0]   SqrtRes_i;
  logic [TAG_WIDTH-1:0]  SqrtTag_i;
  logic [STAT_WIDTH-1:0] SqrtStatus_i;
  logic                  Valid_o;
  logic                  Ready_i;
  logic [FP_WIDTH-1:0]   Res_o;
  logic [TAG_WIDTH-1:0]  Tag_o;
  logic [STAT_WIDTH-1:0] Status_o;
  logic                  Empty_o;
  logic                  Overflow_o;

  modport slave (
    input  Issue_i, SqrtValid_i, SqrtRes_i, SqrtTag_i, SqrtStatus_i, Ready_i,
    output CanIssue_o, Valid_o, Res_o, Tag_o, Status_o, Empty_o, Overflow_o
  );

  modport master (
    output Issue_i, SqrtValid_i, SqrtRes_i, SqrtTag_i, SqrtStatus_i, Ready_i,
    input  CanIssue_o, Valid_o, Res_o, Tag_o, Status_o, Empty_o, Overflow_o
  );
endinterface

// File: rtl/fp_sqrt_result_buffer.sv
// Result FIFO and credit tracker behind the non-stallable FP sqrt wrapper.
// Credits guarantee a free slot for every issued op; a result arriving when full is dropped.
module fp_sqrt_result_buffer #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned STAT_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  fp_sqrt_result_buffer_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CntW-1:0] credits_q, credits_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            overflow_q, overflow_d;

  logic [FP_WIDTH-1:0]   res_mem_q  [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem_q  [DEPTH];
  logic [STAT_WIDTH-1:0] stat_mem_q [DEPTH];

  logic can_issue, valid, full, issue, pop, push, drop;

  assign can_issue = (credits_q != '0);
  assign valid     = (occ_q != '0);
  assign full      = (occ_q == CntW'(DEPTH));
  assign issue     = bus_io.Issue_i & can_issue;
  assign pop       = valid & bus_io.Ready_i;
  // When full, a same-cycle pop frees the slot the incoming result lands in.
  assign push      = bus_io.SqrtValid_i & (~full | pop);
  assign drop      = bus_io.SqrtValid_i & full & ~pop;

  always_comb begin
    credits_d  = credits_q;
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q | drop;

    if (issue && !pop) begin
      credits_d = credits_q - CntW'(1);
    end else if (pop && !issue) begin
      credits_d = credits_q + CntW'(1);
    end

    if (push && !pop) begin
      occ_d = occ_q + CntW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CntW'(1);
    end

    if (push) begin
      wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q  <= CntW'(DEPTH);
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; Valid_o qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem_q[wptr_q]  <= bus_io.SqrtRes_i;
      tag_mem_q[wptr_q]  <= bus_io.SqrtTag_i;
      stat_mem_q[wptr_q] <= bus_io.SqrtStatus_i;
    end
  end

  assign bus_io.CanIssue_o = can_issue;
  assign bus_io.Valid_o    = valid;
  assign bus_io.Res_o      = res_mem_q[rptr_q];
  assign bus_io.Tag_o      = tag_mem_q[rptr_q];
  assign bus_io.Status_o   = stat_mem_q[rptr_q];
  assign bus_io.Empty_o    = (occ_q == '0) && (credits_q == CntW'(DEPTH));
  assign bus_io.Overflow_o = overflow_q;

endmodule

// File: tb/tb_fp_sqrt_result_buffer.sv
// Directed table-driven bench for fp_sqrt_result_buffer (DEPTH=4) plus hand-written
// reset-mid-operation and back-pressure hold sequences.
module tb_fp_sqrt_result_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_sqrt_result_buffer_if #(.FP_WIDTH(32), .TAG_WIDTH(5), .STAT_WIDTH(5)) bus ();

  fp_sqrt_result_buffer #(
    .FP_WIDTH  (32),
    .TAG_WIDTH (5),
    .STAT_WIDTH(5),
    .DEPTH     (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus.slave)
  );

  typedef struct {
    logic       issue;
    logic       sv;
    logic [4:0] tag;
    logic       ready;
    logic       e_can;
    logic       e_valid;
    logic [4:0] e_tag;
    logic       e_empty;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] res_of(input logic [4:0] t);
    return (t == 5'd3) ? 32'h4000_0000 : 32'h3F80_0000 + {t, 12'h000};
  endfunction

  function automatic logic [4:0] stat_of(input logic [4:0] t);
    return t ^ 5'h0A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic issue, input logic sv, input logic [4:0] tag,
                       input logic ready);
    bus.Issue_i      = issue;
    bus.SqrtValid_i  = sv;
    bus.SqrtTag_i    = tag;
    bus.SqrtRes_i    = res_of(tag);
    bus.SqrtStatus_i = stat_of(tag);
    bus.Ready_i      = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [4:0] t);
    chk({name, ".tag"}, {27'd0, bus.Tag_o}, {27'd0, t});
    chk({name, ".res"}, bus.Res_o, res_of(t));
    chk({name, ".status"}, {27'd0, bus.Status_o}, {27'd0, stat_of(t)});
  endtask

  task automatic add(input logic i, input logic s, input logic [4:0] t, input logic r,
                     input logic c, input logic v, input logic [4:0] et, input logic e,
                     input logic o);
    vec_t x;
    x = '{issue: i, sv: s, tag: t, ready: r, e_can: c, e_valid: v, e_tag: et,
          e_empty: e, e_ovf: o};
    vecs.push_back(x);
  endtask

  initial begin
    // Single op
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 1, 3, 1,  1, 1, 3, 0, 0);
    add(0, 0, 0, 1,  1, 0, 0, 1, 0);
    // Credit exhaustion; 5th issue ignored
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0);
    // Fill with tags 0..3
    add(0, 1, 0, 0,  0, 1, 0, 0, 0);
    add(0, 1, 1, 0,  0, 1, 0, 0, 0);
    add(0, 1, 2, 0,  0, 1, 0, 0, 0);
    add(0, 1, 3, 0,  0, 1, 0, 0, 0);
    // Push tag 4 while popping tag 0 at full; credit returns next cycle
    add(0, 1, 4, 1,  1, 1, 1, 0, 0);
    add(1, 0, 0, 1,  1, 1, 2, 0, 0);
    add(0, 0, 0, 1,  1, 1, 3, 0, 0);
    add(0, 0, 0, 1,  1, 1, 4, 0, 0);
    add(0, 0, 0, 1,  1, 0, 0, 1, 0);
    // Overflow: fill 10..13, tag 7 dropped
    add(1, 1, 10, 0, 1, 1, 10, 0, 0);
    add(1, 1, 11, 0, 1, 1, 10, 0, 0);
    add(1, 1, 12, 0, 1, 1, 10, 0, 0);
    add(1, 1, 13, 0, 0, 1, 10, 0, 0);
    add(0, 1, 7, 0,  0, 1, 10, 0, 1);
    add(0, 0, 0, 0,  0, 1, 10, 0, 1);
    add(0, 0, 0, 1,  1, 1, 11, 0, 1);
    add(0, 0, 0, 1,  1, 1, 12, 0, 1);
    add(0, 0, 0, 1,  1, 1, 13, 0, 1);
    add(0, 0, 0, 1,  1, 0, 0, 1, 1);

    drive(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset.can_issue", {31'd0, bus.CanIssue_o}, 32'd1);
    chk("reset.valid", {31'd0, bus.Valid_o}, 32'd0);
    chk("reset.empty", {31'd0, bus.Empty_o}, 32'd1);
    chk("reset.overflow", {31'd0, bus.Overflow_o}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].issue, vecs[i].sv, vecs[i].tag, vecs[i].ready);
      step();
      chk({nm, ".can_issue"}, {31'd0, bus.CanIssue_o}, {31'd0, vecs[i].e_can});
      chk({nm, ".valid"}, {31'd0, bus.Valid_o}, {31'd0, vecs[i].e_valid});
      chk({nm, ".empty"}, {31'd0, bus.Empty_o}, {31'd0, vecs[i].e_empty});
      chk({nm, ".overflow"}, {31'd0, bus.Overflow_o}, {31'd0, vecs[i].e_ovf});
      if (vecs[i].e_valid) chk_head(nm, vecs[i].e_tag);
    end

    // Reset mid-operation: 2 entries buffered, 1 credit outstanding, overflow still set
    drive(1, 1, 20, 0);
    step();
    drive(0, 1, 21, 0);
    step();
    chk("midrst.pre_valid", {31'd0, bus.Valid_o}, 32'd1);
    chk("midrst.pre_empty", {31'd0, bus.Empty_o}, 32'd0);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.valid", {31'd0, bus.Valid_o}, 32'd0);
    chk("midrst.can_issue", {31'd0, bus.CanIssue_o}, 32'd1);
    chk("midrst.empty", {31'd0, bus.Empty_o}, 32'd1);
    chk("midrst.overflow", {31'd0, bus.Overflow_o}, 32'd0);

    // Back-pressure hold: head stays tag 9 while more results arrive
    drive(1, 1, 9, 0);
    step();
    chk_head("hold.first", 5'd9);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1, 1, 5'(14 + c), 0);
      else drive(0, 0, 0, 0);
      step();
      chk($sformatf("hold%0d.valid", c), {31'd0, bus.Valid_o}, 32'd1);
      chk_head($sformatf("hold%0d", c), 5'd9);
    end
    chk("hold.can_issue", {31'd0, bus.CanIssue_o}, 32'd0);

    // Drain in order
    drive(0, 0, 0, 1);
    for (int d = 0; d < 3; d++) begin
      step();
      chk_head($sformatf("drain%0d", d), 5'(14 + d));
    end
    step();
    chk("drain.valid", {31'd0, bus.Valid_o}, 32'd0);
    chk("drain.empty", {31'd0, bus.Empty_o}, 32'd1);
    chk("drain.overflow", {31'd0, bus.Overflow_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
